// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: word array with a program-load port and a fetch port with fault checks.
// Latency: one cycle from an accepted fetch to rsp_valid, one fetch per cycle while rsp_ready is high.
// Backpressure: req_ready = !rsp_valid || rsp_ready; the response register holds while stalled.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr    - fetch request, byte address
//   rsp_valid/rsp_ready             - response handshake
//   rsp_instr/rsp_fault             - fetched word; fault 00 ok, 01 misaligned, 10 out of range
//   ld_en/ld_idx/ld_data            - program-load write port, word indexed, never stalls fetch
//   flush                           - drops the pending response and any fetch accepted this cycle
module instr_fetch_mem #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 512,
    parameter int                ADDR_W     = 32,
    parameter logic [DATA_W-1:0] FAULT_WORD = '0,
    localparam int               IDX_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [1:0]        rsp_fault,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              flush
);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    // Contents are deliberately left out of reset so a loaded program survives it.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic              accept;
    logic              misaligned;
    logic              out_of_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] nxt_instr;
    logic [1:0]        nxt_fault;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    assign rd_idx       = req_addr[IDX_W+1:2];
    assign misaligned   = (req_addr[1:0] != 2'b00);
    // Compared at 64 bits so the check stays correct when ADDR_W leaves no bits above the index.
    assign out_of_range = (64'(req_addr >> 2) >= 64'(DEPTH));

    // Misalignment wins over out-of-range; the array is only read for a clean fetch.
    always_comb begin
        nxt_instr = FAULT_WORD;
        nxt_fault = FAULT_OK;
        if (misaligned) begin
            nxt_fault = FAULT_ALIGN;
        end else if (out_of_range) begin
            nxt_fault = FAULT_RANGE;
        end else begin
            nxt_instr = mem[rd_idx];
        end
    end

    // Write uses a non-blocking update, so a same-cycle fetch of the same word sees the old value.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // Flush beats both a new fetch and a completing handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_fault <= FAULT_OK;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_instr <= nxt_instr;
            rsp_fault <= nxt_fault;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter DEPTH, default 512: number of instruction words; power of two, at least 2.
REQ-003 Parameter ADDR_W, default 32: byte-address width of the fetch request.
REQ-004 Parameter FAULT_WORD, default 32'h00000000: value returned on rsp_instr for a faulted fetch.
REQ-005 Derived IDX_W = log2(DEPTH).
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port req_valid, input, 1: fetch request present.
REQ-009 Port req_ready, output, 1: block accepts a fetch this cycle.
REQ-010 Port req_addr, input, ADDR_W: byte address of the requested instruction.
REQ-011 Port rsp_valid, output, 1: response held on rsp_instr and rsp_fault.
REQ-012 Port rsp_ready, input, 1: consumer takes the response this cycle.
REQ-013 Port rsp_instr, output, DATA_W: fetched instruction word.
REQ-014 Port rsp_fault, output, 2: 00 ok, 01 misaligned, 10 out of range.
REQ-015 Port ld_en, input, 1: program-load write strobe.
REQ-016 Port ld_idx, input, IDX_W: word index to load.
REQ-017 Port ld_data, input, DATA_W: word to load.
REQ-018 Port flush, input, 1: discard the pending response (branch redirect).

Function
REQ-019 Storage: DEPTH x DATA_W word array, word-indexed; index = req_addr[IDX_W+1:2].
REQ-020 Accept: a fetch is accepted when req_valid && req_ready at a rising edge.
REQ-021 req_ready = !rsp_valid || rsp_ready (single output register, combinational ready).
REQ-022 Latency: exactly one cycle; the response for a fetch accepted at edge N is valid after edge N.
REQ-023 Throughput: one fetch per cycle while rsp_ready stays high.
REQ-024 Response fields hold stable while rsp_valid && !rsp_ready.
REQ-025 Misaligned: req_addr[1:0] != 0 -> rsp_fault=01, rsp_instr=FAULT_WORD; the array is not read.
REQ-026 Out of range: aligned, but req_addr >> 2 >= DEPTH -> rsp_fault=10, rsp_instr=FAULT_WORD.
REQ-027 Fault priority: misaligned over out of range.
REQ-028 Load: ld_en writes ld_data to word ld_idx at the edge; no handshake; it never stalls fetch.
REQ-029 Load and fetch of the same index in one cycle: the fetch returns the old word (read-before-write).
REQ-030 Flush: at the edge, rsp_valid -> 0 and any fetch accepted in the same cycle is discarded; req_ready is unaffected by flush in that cycle.
REQ-031 Flush takes priority over a simultaneous rsp_ready handshake; the flushed response counts as not delivered.
REQ-032 When rsp_valid=0, rsp_instr and rsp_fault hold their last values; they carry no meaning.

Reset
REQ-033 While rst_n=0: rsp_valid=0, rsp_instr=0, rsp_fault=00, so req_ready=1.
REQ-034 Array contents are not reset and keep their values across reset; contents after power-up are zero-initialised for simulation.
REQ-035 Reset asserted mid-operation drops any pending response immediately, without waiting for clk.
REQ-036 No fetch is accepted in the first edge after reset deasserts unless req_valid is high at that edge.

Verification
REQ-037 Load idx0=22310000, idx3=014a6020; fetch 0x0 then 0xC with rsp_ready=1 -> responses 22310000 then 014a6020, fault 00, back-to-back cycles.
REQ-038 Fetch 0x6 -> rsp_fault=01, rsp_instr=00000000; fetch 0x800 with DEPTH=512 -> rsp_fault=10.
REQ-039 Hold rsp_ready=0 for 3 cycles after a fetch of 0x8 -> req_ready=0 and rsp_instr stable for those 3 cycles; release -> next fetch is accepted the same cycle.
REQ-040 Same cycle: ld_en idx2=2008004b (old value 0) and fetch 0x8 -> response 00000000; a refetch of 0x8 -> 2008004b.
REQ-041 Flush in the cycle a fetch of 0x4 is accepted -> no response appears; the following fetch of 0x0 responds normally.
REQ-042 Pulse rst_n low between edges while rsp_valid=1 -> rsp_valid falls immediately; after release, the contents loaded at idx0 are still present.
